fir_cfg_regs: RTL

Parametrised configuration/status register block for the multi-channel decimating FIR front end; successor to the single-channel coefficient register block. Exposes an 8-bit req/wr_en bus to the host and drives per-channel coefficients, divider, decimation ratio and enable to the datapath. Writes land in shadow registers and reach the datapath only on a committed, sample-aligned update. Also monitors ADC samples for full-scale overflow.

---
 rtl/fir_cfg_pkg.sv | 37 +++
 rtl/fir_cfg_regs_if.sv | 12 +
 rtl/fir_cfg_chan.sv | 79 +++++++
 rtl/fir_cfg_regs.sv | 107 ++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// Shared constants and types for the FIR configuration register block:
// address map, reset values and MODE field layout.
package fir_cfg_pkg;

  localparam int CH_STRIDE = 16;

  localparam logic [3:0] COEF_DIV_OFS = 4'hC;
  localparam logic [3:0] MODE_OFS     = 4'hD;

  localparam logic [7:0] ID_ADDR     = 8'hF0;
  localparam logic [7:0] CTRL_ADDR   = 8'hF1;
  localparam logic [7:0] STATUS_ADDR = 8'hF2;
  localparam logic [7:0] IRQ_EN_ADDR = 8'hF3;

  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_PENDING_BIT = 1;

  localparam logic [7:0] COEF_RST     = 8'h00;
  localparam logic [7:0] COEF_DIV_RST = 8'h01;
  localparam logic [1:0] RATIO_RST    = 2'd0;
  localparam logic       CONV_EN_RST  = 1'b0;

  localparam int MODE_RATIO_LSB   = 0;
  localparam int MODE_CONV_EN_BIT = 7;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_wr_t;

  // Full-scale codes in either direction count as overflow.
  function automatic logic is_overflow(input logic [7:0] s);
    return (s == 8'h80) || (s == 8'h7F);
  endfunction

endpackage

// File: rtl/fir_cfg_regs_if.sv
// Host register bus: one-cycle req strobe, wr_en selects write, registered read return.
interface fir_cfg_regs_if;
  logic       req;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (output req, wr_en, addr, wr_data, input rd_data, rd_valid);
  modport slave  (input req, wr_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/fir_cfg_chan.sv
// One channel: shadow registers written by the host, active registers that
// take a snapshot of the shadows when apply is asserted.
module fir_cfg_chan
  import fir_cfg_pkg::*;
#(
  parameter int CH_IDX   = 0,
  parameter int NUM_TAPS = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  bus_wr_t                  wr,
  input  logic [7:0]               rd_addr,
  input  logic                     apply,
  output logic [7:0]               rd_val,
  output logic [NUM_TAPS-1:0][7:0] coef,
  output logic [7:0]               coef_div,
  output logic [1:0]               ratio,
  output logic                     conv_en
);

  localparam logic [7:0] BASE = 8'(CH_IDX * CH_STRIDE);

  logic [NUM_TAPS-1:0][7:0] coef_sh;
  logic [7:0]               div_sh;
  logic [1:0]               ratio_sh;
  logic                     en_sh;

  logic       wr_sel;
  logic [3:0] wr_ofs;

  assign wr_sel = wr.wr && (wr.addr[7:4] == BASE[7:4]);
  assign wr_ofs = wr.addr[3:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      coef_sh  <= {NUM_TAPS{COEF_RST}};
      div_sh   <= COEF_DIV_RST;
      ratio_sh <= RATIO_RST;
      en_sh    <= CONV_EN_RST;
    end else if (wr_sel) begin
      for (int t = 0; t < NUM_TAPS; t++)
        if (wr_ofs == 4'(t)) coef_sh[t] <= wr.data;
      if (wr_ofs == COEF_DIV_OFS) div_sh <= wr.data;
      if (wr_ofs == MODE_OFS) begin
        ratio_sh <= wr.data[MODE_RATIO_LSB +: 2];
        en_sh    <= wr.data[MODE_CONV_EN_BIT];
      end
    end
  end

  // Snapshot takes the shadow values as they stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      coef     <= {NUM_TAPS{COEF_RST}};
      coef_div <= COEF_DIV_RST;
      ratio    <= RATIO_RST;
      conv_en  <= CONV_EN_RST;
    end else if (apply) begin
      coef     <= coef_sh;
      coef_div <= div_sh;
      ratio    <= ratio_sh;
      conv_en  <= en_sh;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    if (rd_addr[7:4] == BASE[7:4]) begin
      for (int t = 0; t < NUM_TAPS; t++)
        if (rd_addr[3:0] == 4'(t)) rd_val = coef_sh[t];
      if (rd_addr[3:0] == COEF_DIV_OFS) rd_val = div_sh;
      if (rd_addr[3:0] == MODE_OFS) begin
        rd_val[MODE_RATIO_LSB +: 2]  = ratio_sh;
        rd_val[MODE_CONV_EN_BIT]     = en_sh;
      end
    end
  end

endmodule

// File: rtl/fir_cfg_regs.sv
// Multi-channel FIR config/status registers: per-channel shadow/active banks,
// sample-aligned commit, overflow sticky status with interrupt.
module fir_cfg_regs
  import fir_cfg_pkg::*;
#(
  parameter int         NUM_CH     = 2,
  parameter int         NUM_TAPS   = 3,
  parameter logic [7:0] ID_VERSION = 8'h21
) (
  input  logic                         clk,
  input  logic                         reset_n,
  fir_cfg_regs_if.slave                bus,
  input  logic                         I_sample_stb,
  input  logic [NUM_CH*8-1:0]          I_adc_data,
  output logic [NUM_CH*NUM_TAPS*8-1:0] O_coef,
  output logic [NUM_CH*8-1:0]          O_coef_div,
  output logic [NUM_CH*2-1:0]          O_decimation_ratio,
  output logic [NUM_CH-1:0]            O_conv_en,
  output logic                         O_update_pending,
  output logic                         O_irq
);

  logic wr_stb, rd_stb, commit_wr, apply;
  bus_wr_t wr_req;

  logic [NUM_CH-1:0] status, status_nxt, irq_en, irq_en_nxt, ovf_set, w1c;
  logic [NUM_CH-1:0][7:0] chan_rd;
  logic [7:0] chan_rd_or, rd_mux;
  logic pending;

  assign wr_stb    = bus.req && bus.wr_en;
  assign rd_stb    = bus.req && !bus.wr_en;
  assign wr_req    = '{wr: wr_stb, addr: bus.addr, data: bus.wr_data};
  assign commit_wr = wr_stb && (bus.addr == CTRL_ADDR) && bus.wr_data[CTRL_COMMIT_BIT];
  // pending is still low in the COMMIT cycle, so a coincident strobe cannot apply.
  assign apply     = pending && I_sample_stb;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fir_cfg_chan #(.CH_IDX(c), .NUM_TAPS(NUM_TAPS)) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr       (wr_req),
      .rd_addr  (bus.addr),
      .apply    (apply),
      .rd_val   (chan_rd[c]),
      .coef     (O_coef[c*NUM_TAPS*8 +: NUM_TAPS*8]),
      .coef_div (O_coef_div[c*8 +: 8]),
      .ratio    (O_decimation_ratio[c*2 +: 2]),
      .conv_en  (O_conv_en[c])
    );
  end

  always_comb begin
    ovf_set = '0;
    for (int c = 0; c < NUM_CH; c++)
      ovf_set[c] = I_sample_stb && is_overflow(I_adc_data[c*8 +: 8]);
  end

  // Set is OR'd in after the clear so a coincident overflow wins.
  assign w1c        = (wr_stb && bus.addr == STATUS_ADDR) ? bus.wr_data[NUM_CH-1:0] : '0;
  assign status_nxt = (status & ~w1c) | ovf_set;
  assign irq_en_nxt = (wr_stb && bus.addr == IRQ_EN_ADDR) ? bus.wr_data[NUM_CH-1:0] : irq_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= 1'b0;
      status  <= '0;
      irq_en  <= '0;
      O_irq   <= 1'b0;
    end else begin
      if (apply)          pending <= 1'b0;
      else if (commit_wr) pending <= 1'b1;
      status <= status_nxt;
      irq_en <= irq_en_nxt;
      O_irq  <= |(status_nxt & irq_en_nxt);
    end
  end

  assign O_update_pending = pending;

  always_comb begin
    chan_rd_or = 8'h00;
    for (int c = 0; c < NUM_CH; c++) chan_rd_or |= chan_rd[c];
  end

  always_comb begin
    rd_mux = chan_rd_or;
    case (bus.addr)
      ID_ADDR:     rd_mux = ID_VERSION;
      CTRL_ADDR:   rd_mux = 8'(pending) << CTRL_PENDING_BIT;
      STATUS_ADDR: rd_mux = 8'(status);
      IRQ_EN_ADDR: rd_mux = 8'(irq_en);
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rd_data  <= 8'h00;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_stb;
      if (rd_stb) bus.rd_data <= rd_mux;
    end
  end

endmodule
